// File: rtl/sa_pkg.sv
// Shared types and width helpers for the systolic-array host side.
package sa_pkg;

  typedef enum logic [3:0] {
    StIdle,
    StLoadA,
    StLoadB,
    StLoadI,
    StStart,
    StWait,
    StCheck,
    StDrain,
    StDone
  } sa_state_e;

  // Address width that stays at least one bit for degenerate depths.
  function automatic int unsigned sa_clog2(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  function automatic int unsigned sa_words_per_instr(input int unsigned rows);
    return rows * rows;
  endfunction

endpackage

// File: rtl/sa_check_pipe.sv
// Read-latency delay line of {valid, index, expected} with result comparator and tallies.
module sa_check_pipe #(
  parameter int unsigned RD_LAT = 1,
  parameter int unsigned OW     = 32,
  parameter int unsigned OAW    = 7,
  parameter int unsigned CW     = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           i_clear,
  input  logic           i_push,
  input  logic [OAW-1:0] i_idx,
  input  logic [OW-1:0]  i_exp,
  input  logic [OW-1:0]  i_data,
  output logic           o_pending,
  output logic [CW-1:0]  o_pass_count,
  output logic [CW-1:0]  o_fail_count,
  output logic [OAW-1:0] o_first_fail
);

  localparam int unsigned Last = RD_LAT - 1;

  logic [RD_LAT-1:0] r_vld;
  logic [OAW-1:0]    r_idx [RD_LAT];
  logic [OW-1:0]     r_exp [RD_LAT];
  logic [CW-1:0]     r_pass;
  logic [CW-1:0]     r_fail;
  logic [OAW-1:0]    r_first;

  always_ff @(posedge clk) begin
    if (rst || i_clear) begin
      r_vld   <= '0;
      r_pass  <= '0;
      r_fail  <= '0;
      r_first <= '0;
      for (int i = 0; i < int'(RD_LAT); i++) begin
        r_idx[i] <= '0;
        r_exp[i] <= '0;
      end
    end else begin
      r_vld[0] <= i_push;
      r_idx[0] <= i_idx;
      r_exp[0] <= i_exp;
      for (int i = 1; i < int'(RD_LAT); i++) begin
        r_vld[i] <= r_vld[i-1];
        r_idx[i] <= r_idx[i-1];
        r_exp[i] <= r_exp[i-1];
      end
      if (r_vld[Last]) begin
        if (i_data == r_exp[Last]) begin
          r_pass <= r_pass + 1'b1;
        end else begin
          if (r_fail == '0) r_first <= r_idx[Last];
          r_fail <= r_fail + 1'b1;
        end
      end
    end
  end

  // The exit stage is consumed on this edge, so only earlier stages count as pending.
  always_comb begin
    o_pending = 1'b0;
    for (int i = 0; i + 1 < int'(RD_LAT); i++) begin
      o_pending = o_pending | r_vld[i];
    end
  end

  assign o_pass_count = r_pass;
  assign o_fail_count = r_fail;
  assign o_first_fail = r_first;

endmodule

// File: rtl/sa_host_sequencer.sv
// Host sequencer: loads A/B/instruction memories, starts the array, then checks results.
module sa_host_sequencer
  import sa_pkg::*;
#(
  parameter int unsigned ROWS      = 4,
  parameter int unsigned DEPTH     = 256,
  parameter int unsigned DW        = 16,
  parameter int unsigned OW        = 32,
  parameter int unsigned IW        = 4,
  parameter int unsigned INUM      = 8,
  parameter int unsigned ODEPTH    = 128,
  parameter int unsigned RD_LAT    = 1,
  parameter int unsigned SHARED_AB = 1,
  parameter int unsigned TIMEOUT   = 65535,
  localparam int unsigned AW       = sa_clog2(ROWS * DEPTH),
  localparam int unsigned IAW      = sa_clog2(INUM),
  localparam int unsigned OAW      = sa_clog2(ODEPTH),
  localparam int unsigned CW       = OAW + 1
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           go,
  input  logic [IW-1:0]  cfg_n,
  input  logic           s_valid,
  output logic           s_ready,
  input  logic [DW-1:0]  s_data,
  input  logic           e_valid,
  output logic           e_ready,
  input  logic [OW-1:0]  e_data,
  output logic [AW-1:0]  addrA,
  output logic [DW-1:0]  dataA,
  output logic           enA,
  output logic [AW-1:0]  addrB,
  output logic [DW-1:0]  dataB,
  output logic           enB,
  output logic [IAW-1:0] addrI,
  output logic [IW-1:0]  dataI,
  output logic           enI,
  output logic [OAW-1:0] addrO,
  input  logic [OW-1:0]  dataO,
  output logic           ap_start,
  input  logic           ap_done,
  output logic           busy,
  output logic           done,
  output logic           timeout,
  output logic [CW-1:0]  pass_count,
  output logic [CW-1:0]  fail_count,
  output logic [OAW-1:0] first_fail
);

  localparam int unsigned LW  = (AW > IAW) ? AW : IAW;
  localparam int unsigned TW  = sa_clog2(TIMEOUT + 1);
  localparam int unsigned Wpi = sa_words_per_instr(ROWS);
  localparam logic [LW-1:0] LastAB   = LW'(ROWS * DEPTH - 1);
  localparam logic [LW-1:0] LastI    = LW'(INUM - 1);
  localparam logic [TW-1:0] LastWait = TW'(TIMEOUT - 1);

  sa_state_e      r_state, w_state_d;
  logic [LW-1:0]  r_ld_cnt, w_ld_cnt_d;
  logic [TW-1:0]  r_wait_cnt, w_wait_cnt_d;
  logic [CW-1:0]  r_total, w_total_d, w_total_go;
  logic [CW-1:0]  r_iss, w_iss_d, w_iss_next;
  logic [AW-1:0]  r_addr_a, w_addr_a_d, r_addr_b, w_addr_b_d;
  logic [DW-1:0]  r_data_a, w_data_a_d, r_data_b, w_data_b_d;
  logic [IAW-1:0] r_addr_i, w_addr_i_d;
  logic [IW-1:0]  r_data_i, w_data_i_d;
  logic [OAW-1:0] r_addr_o, w_addr_o_d;
  logic           r_en_a, w_en_a_d, r_en_b, w_en_b_d, r_en_i, w_en_i_d;
  logic           r_s_ready, w_s_ready_d, r_e_ready, w_e_ready_d;
  logic           r_ap_start, w_ap_start_d;
  logic           r_busy, w_busy_d, r_done, w_done_d, r_timeout, w_timeout_d;
  logic           w_s_acc, w_e_acc, w_push, w_clear, w_pending;
  int unsigned    w_prod;

  assign w_s_acc    = s_valid & r_s_ready;
  assign w_e_acc    = e_valid & r_e_ready;
  assign w_iss_next = r_iss + 1'b1;

  always_comb begin
    w_prod     = Wpi * 32'(cfg_n);
    w_total_go = (w_prod > ODEPTH) ? CW'(ODEPTH) : CW'(w_prod);
  end

  always_comb begin
    w_state_d    = r_state;
    w_ld_cnt_d   = r_ld_cnt;
    w_wait_cnt_d = r_wait_cnt;
    w_total_d    = r_total;
    w_iss_d      = r_iss;
    w_addr_a_d   = r_addr_a;
    w_data_a_d   = r_data_a;
    w_addr_b_d   = r_addr_b;
    w_data_b_d   = r_data_b;
    w_addr_i_d   = r_addr_i;
    w_data_i_d   = r_data_i;
    w_addr_o_d   = r_addr_o;
    w_en_a_d     = 1'b0;
    w_en_b_d     = 1'b0;
    w_en_i_d     = 1'b0;
    w_ap_start_d = 1'b0;
    w_timeout_d  = r_timeout;
    w_push       = 1'b0;
    w_clear      = 1'b0;

    unique case (r_state)
      StIdle, StDone: begin
        if (go) begin
          w_state_d   = StLoadA;
          w_ld_cnt_d  = '0;
          w_total_d   = w_total_go;
          w_iss_d     = '0;
          w_addr_o_d  = '0;
          w_timeout_d = 1'b0;
          w_clear     = 1'b1;
        end
      end
      StLoadA: begin
        if (w_s_acc) begin
          w_en_a_d   = 1'b1;
          w_addr_a_d = r_ld_cnt[AW-1:0];
          w_data_a_d = s_data;
          if (SHARED_AB != 0) begin
            w_en_b_d   = 1'b1;
            w_addr_b_d = r_ld_cnt[AW-1:0];
            w_data_b_d = s_data;
          end
          w_ld_cnt_d = r_ld_cnt + 1'b1;
          if (r_ld_cnt == LastAB) begin
            w_ld_cnt_d = '0;
            w_state_d  = (SHARED_AB != 0) ? StLoadI : StLoadB;
          end
        end
      end
      StLoadB: begin
        if (w_s_acc) begin
          w_en_b_d   = 1'b1;
          w_addr_b_d = r_ld_cnt[AW-1:0];
          w_data_b_d = s_data;
          w_ld_cnt_d = r_ld_cnt + 1'b1;
          if (r_ld_cnt == LastAB) begin
            w_ld_cnt_d = '0;
            w_state_d  = StLoadI;
          end
        end
      end
      StLoadI: begin
        if (w_s_acc) begin
          w_en_i_d   = 1'b1;
          w_addr_i_d = r_ld_cnt[IAW-1:0];
          w_data_i_d = s_data[IW-1:0];
          w_ld_cnt_d = r_ld_cnt + 1'b1;
          if (r_ld_cnt == LastI) begin
            w_ld_cnt_d = '0;
            w_state_d  = StStart;
          end
        end
      end
      StStart: begin
        w_ap_start_d = 1'b1;
        w_wait_cnt_d = '0;
        w_state_d    = StWait;
      end
      StWait: begin
        // A stale ap_done from the previous run is masked while the start pulse is out.
        if (ap_done && !r_ap_start) begin
          w_state_d  = (r_total == '0) ? StDone : StCheck;
          w_iss_d    = '0;
          w_addr_o_d = '0;
        end else if (r_wait_cnt == LastWait) begin
          w_state_d   = StDone;
          w_timeout_d = 1'b1;
        end else begin
          w_wait_cnt_d = r_wait_cnt + 1'b1;
        end
      end
      StCheck: begin
        if (w_e_acc) begin
          w_push     = 1'b1;
          w_iss_d    = w_iss_next;
          w_addr_o_d = w_iss_next[OAW-1:0];
          if (w_iss_next == r_total) w_state_d = StDrain;
        end
      end
      StDrain: begin
        if (!w_pending) w_state_d = StDone;
      end
      default: w_state_d = StIdle;
    endcase

    w_s_ready_d = (w_state_d == StLoadA) || (w_state_d == StLoadB) || (w_state_d == StLoadI);
    w_e_ready_d = (w_state_d == StCheck);
    w_busy_d    = (w_state_d != StIdle) && (w_state_d != StDone);
    w_done_d    = (w_state_d == StDone);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= StIdle;
      r_ld_cnt   <= '0;
      r_wait_cnt <= '0;
      r_total    <= '0;
      r_iss      <= '0;
      r_addr_a   <= '0;
      r_data_a   <= '0;
      r_addr_b   <= '0;
      r_data_b   <= '0;
      r_addr_i   <= '0;
      r_data_i   <= '0;
      r_addr_o   <= '0;
      r_en_a     <= 1'b0;
      r_en_b     <= 1'b0;
      r_en_i     <= 1'b0;
      r_s_ready  <= 1'b0;
      r_e_ready  <= 1'b0;
      r_ap_start <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_timeout  <= 1'b0;
    end else begin
      r_state    <= w_state_d;
      r_ld_cnt   <= w_ld_cnt_d;
      r_wait_cnt <= w_wait_cnt_d;
      r_total    <= w_total_d;
      r_iss      <= w_iss_d;
      r_addr_a   <= w_addr_a_d;
      r_data_a   <= w_data_a_d;
      r_addr_b   <= w_addr_b_d;
      r_data_b   <= w_data_b_d;
      r_addr_i   <= w_addr_i_d;
      r_data_i   <= w_data_i_d;
      r_addr_o   <= w_addr_o_d;
      r_en_a     <= w_en_a_d;
      r_en_b     <= w_en_b_d;
      r_en_i     <= w_en_i_d;
      r_s_ready  <= w_s_ready_d;
      r_e_ready  <= w_e_ready_d;
      r_ap_start <= w_ap_start_d;
      r_busy     <= w_busy_d;
      r_done     <= w_done_d;
      r_timeout  <= w_timeout_d;
    end
  end

  sa_check_pipe #(
    .RD_LAT (RD_LAT),
    .OW     (OW),
    .OAW    (OAW),
    .CW     (CW)
  ) u_check_pipe (
    .clk          (clk),
    .rst          (rst),
    .i_clear      (w_clear),
    .i_push       (w_push),
    .i_idx        (r_iss[OAW-1:0]),
    .i_exp        (e_data),
    .i_data       (dataO),
    .o_pending    (w_pending),
    .o_pass_count (pass_count),
    .o_fail_count (fail_count),
    .o_first_fail (first_fail)
  );

  assign s_ready  = r_s_ready;
  assign e_ready  = r_e_ready;
  assign addrA    = r_addr_a;
  assign dataA    = r_data_a;
  assign enA      = r_en_a;
  assign addrB    = r_addr_b;
  assign dataB    = r_data_b;
  assign enB      = r_en_b;
  assign addrI    = r_addr_i;
  assign dataI    = r_data_i;
  assign enI      = r_en_i;
  assign addrO    = r_addr_o;
  assign ap_start = r_ap_start;
  assign busy     = r_busy;
  assign done     = r_done;
  assign timeout  = r_timeout;

endmodule
